// File: rtl/adc_cmd_sequencer.sv
// adc_cmd_sequencer: decodes single-character UART commands, runs ADC captures
// and streams each 12-bit sample as two bytes over a valid/ready link.
module adc_cmd_sequencer #(
   parameter logic [7:0] DEFAULT_COUNT = 8'd1,
   parameter logic [2:0] DEFAULT_CH = 3'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_char,
   input  logic        rx_valid,
   output logic        adc_req,
   output logic [2:0]  adc_ch,
   input  logic        adc_valid,
   input  logic [11:0] adc_data,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        busy,
   output logic        done,
   output logic        aborted,
   output logic        cmd_err
);
   typedef enum logic [2:0] {IDLE, ARG_N, ARG_A, CONVERT, SEND_HI, SEND_LO} state_t;
   state_t state, state_n;
   logic [7:0] count, count_n;
   logic [2:0] channel, channel_n;
   logic [8:0] remaining, remaining_n;
   logic [11:0] sample, sample_n;
   logic abort_pending, abort_n, done_n, aborted_n, err_n;
   logic is_x, xfer;
   assign is_x = rx_valid && rx_char == 8'h58;
   assign xfer = tx_valid && tx_ready;
   always_comb begin
      state_n = state;
      count_n = count;
      channel_n = channel;
      remaining_n = remaining;
      sample_n = sample;
      abort_n = abort_pending;
      done_n = 1'b0;
      aborted_n = 1'b0;
      err_n = 1'b0;
      case (state)
         IDLE: if (rx_valid) begin
            if (rx_char == 8'h4E) state_n = ARG_N;
            else if (rx_char == 8'h41) state_n = ARG_A;
            else if (rx_char == 8'h53) begin
               state_n = CONVERT;
               remaining_n = count == 8'd0 ? 9'd256 : {1'b0, count};
            end else if (!is_x) err_n = 1'b1;
         end
         ARG_N: if (rx_valid) begin
            state_n = IDLE;
            if (!is_x) count_n = rx_char;
         end
         ARG_A: if (rx_valid) begin
            state_n = IDLE;
            if (!is_x && rx_char <= 8'd7) channel_n = rx_char[2:0];
            else if (!is_x) err_n = 1'b1;
         end
         CONVERT: begin
            if (is_x) abort_n = 1'b1;
            // a result arriving with the abort still gets sent
            if (adc_valid) begin
               sample_n = adc_data;
               state_n = SEND_HI;
            end else if (abort_pending || is_x) begin
               state_n = IDLE;
               aborted_n = 1'b1;
               abort_n = 1'b0;
            end
         end
         SEND_HI: begin
            if (is_x) abort_n = 1'b1;
            if (xfer) state_n = SEND_LO;
         end
         SEND_LO: begin
            if (is_x) abort_n = 1'b1;
            if (xfer) begin
               remaining_n = remaining - 9'd1;
               if (remaining == 9'd1) begin
                  state_n = IDLE;
                  done_n = 1'b1;
                  abort_n = 1'b0;
               end else if (abort_pending || is_x) begin
                  state_n = IDLE;
                  aborted_n = 1'b1;
                  abort_n = 1'b0;
               end else state_n = CONVERT;
            end
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         count <= DEFAULT_COUNT;
         channel <= DEFAULT_CH;
         remaining <= 9'd0;
         sample <= 12'd0;
         abort_pending <= 1'b0;
         adc_req <= 1'b0;
         adc_ch <= 3'd0;
         tx_valid <= 1'b0;
         tx_data <= 8'h00;
         busy <= 1'b0;
         done <= 1'b0;
         aborted <= 1'b0;
         cmd_err <= 1'b0;
      end else begin
         state <= state_n;
         count <= count_n;
         channel <= channel_n;
         remaining <= remaining_n;
         sample <= sample_n;
         abort_pending <= abort_n;
         // outputs are registered copies of what the next state presents
         adc_req <= state_n == CONVERT;
         adc_ch <= state_n == CONVERT ? channel_n : 3'd0;
         tx_valid <= state_n == SEND_HI || state_n == SEND_LO;
         tx_data <= state_n == SEND_HI ? {channel_n, 1'b0, sample_n[11:8]} :
                    state_n == SEND_LO ? sample_n[7:0] : 8'h00;
         busy <= state_n != IDLE;
         done <= done_n;
         aborted <= aborted_n;
         cmd_err <= err_n;
      end
   end
endmodule

// File: tb/tb_adc_cmd_sequencer.sv
// tb_adc_cmd_sequencer: command table plus ADC/TX models with a byte scoreboard.
module tb_adc_cmd_sequencer;
   logic clk = 1'b0, rst = 1'b1;
   logic [7:0] rx_char = 8'h00;
   logic rx_valid = 1'b0;
   logic adc_req, adc_valid = 1'b0;
   logic [2:0] adc_ch;
   logic [11:0] adc_data = 12'h000;
   logic [7:0] tx_data;
   logic tx_valid, tx_ready = 1'b0;
   logic busy, done, aborted, cmd_err;
   int checks = 0, failures = 0;
   logic [7:0] sb[$];
   int vcount = 0, vlimit = 1 << 30, wait_cnt = 0, ready_mode = 1;
   int bytes = 0, done_cnt = 0, ab_cnt = 0;
   bit force_fire = 0, fixed_en = 0;
   logic [2:0] exp_ch = 3'd0;
   logic pv = 1'b0, pr = 1'b0;
   logic [7:0] pd = 8'h00;
   typedef struct {logic [7:0] c; logic err; logic bsy;} vec_t;
   vec_t tbl[14];

   always #5 clk = ~clk;

   adc_cmd_sequencer dut (
      .clk(clk), .rst(rst), .rx_char(rx_char), .rx_valid(rx_valid),
      .adc_req(adc_req), .adc_ch(adc_ch), .adc_valid(adc_valid), .adc_data(adc_data),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .busy(busy), .done(done), .aborted(aborted), .cmd_err(cmd_err)
   );

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_char(input logic [7:0] c);
      rx_char = c;
      rx_valid = 1'b1;
      step();
      rx_valid = 1'b0;
   endtask

   task automatic chk_zero(input string p);
      chk({p, "_adc_req"}, adc_req, 0);
      chk({p, "_adc_ch"}, adc_ch, 0);
      chk({p, "_tx_valid"}, tx_valid, 0);
      chk({p, "_tx_data"}, tx_data, 0);
      chk({p, "_busy"}, busy, 0);
      chk({p, "_done"}, done, 0);
      chk({p, "_aborted"}, aborted, 0);
      chk({p, "_cmd_err"}, cmd_err, 0);
   endtask

   task automatic wait_idle(input int budget, input logic ed, input logic ea);
      int n = 0;
      while (busy && n < budget) begin
         step();
         n++;
      end
      chk("idle_reached", busy, 0);
      chk("end_done", done, ed);
      chk("end_aborted", aborted, ea);
      chk("end_tx_valid", tx_valid, 0);
   endtask

   task automatic wait_tx(input int budget);
      int n = 0;
      while (!tx_valid && n < budget) begin
         step();
         n++;
      end
      chk("tx_valid_reached", tx_valid, 1);
   endtask

   // ADC model: answers a request after two waiting cycles, pushes the expected byte pair
   initial forever begin
      @(posedge clk);
      #2;
      adc_valid = 1'b0;
      if (rst) wait_cnt = 0;
      else if (force_fire || (adc_req && vcount < vlimit && wait_cnt >= 2)) begin
         adc_data = fixed_en ? 12'hABC : 12'($urandom);
         adc_valid = 1'b1;
         force_fire = 0;
         wait_cnt = 0;
         vcount++;
         chk("adc_ch", adc_ch, exp_ch);
         sb.push_back({exp_ch, 1'b0, adc_data[11:8]});
         sb.push_back(adc_data[7:0]);
      end else wait_cnt = adc_req ? wait_cnt + 1 : 0;
   end

   // TX sink: scores transfers, checks stall stability, drives tx_ready
   initial forever begin
      @(posedge clk);
      #3;
      if (rst) begin
         sb.delete();
         pv = 1'b0;
      end else begin
         if (pv && pr) begin
            bytes++;
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL tx_unexpected: got byte %0h expected none", pd);
            end else chk("tx_byte", pd, sb.pop_front());
         end else if (pv) begin
            chk("stall_valid", tx_valid, 1);
            chk("stall_data", tx_data, pd);
         end
         done_cnt += int'(done);
         ab_cnt += int'(aborted);
         tx_ready = ready_mode == 2 ? ~tx_ready : (ready_mode == 1);
         pv = tx_valid;
         pr = tx_ready;
         pd = tx_data;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int b0, d0, a0, n;
      tbl[0] = '{8'h51, 1'b1, 1'b0};
      tbl[1] = '{8'h58, 1'b0, 1'b0};
      tbl[2] = '{8'h41, 1'b0, 1'b1};
      tbl[3] = '{8'h09, 1'b1, 1'b0};
      tbl[4] = '{8'h41, 1'b0, 1'b1};
      tbl[5] = '{8'h58, 1'b0, 1'b0};
      tbl[6] = '{8'h4E, 1'b0, 1'b1};
      tbl[7] = '{8'h58, 1'b0, 1'b0};
      tbl[8] = '{8'h7A, 1'b1, 1'b0};
      tbl[9] = '{8'h00, 1'b1, 1'b0};
      tbl[10] = '{8'h41, 1'b0, 1'b1};
      tbl[11] = '{8'h07, 1'b0, 1'b0};
      tbl[12] = '{8'h41, 1'b0, 1'b1};
      tbl[13] = '{8'h00, 1'b0, 1'b0};
      repeat (3) step();
      chk_zero("reset");
      rst = 1'b0;
      step();
      for (int i = 0; i < 14; i++) begin
         send_char(tbl[i].c);
         chk($sformatf("cmd%0d_err", i), cmd_err, tbl[i].err);
         chk($sformatf("cmd%0d_busy", i), busy, tbl[i].bsy);
      end
      // default single capture of 0xABC on channel 0
      fixed_en = 1;
      b0 = bytes; d0 = done_cnt;
      send_char(8'h53);
      chk("s_adc_req", adc_req, 1);
      chk("s_busy", busy, 1);
      wait_idle(200, 1, 0);
      fixed_en = 0;
      step(); step();
      chk("single_bytes", bytes, b0 + 2);
      chk("single_done", done_cnt, d0 + 1);
      // channel 5, three samples, toggling ready
      send_char(8'h41); send_char(8'h05); exp_ch = 3'd5;
      send_char(8'h4E); send_char(8'h03);
      ready_mode = 2;
      b0 = bytes; d0 = done_cnt;
      send_char(8'h53);
      wait_idle(400, 1, 0);
      step(); step();
      chk("three_bytes", bytes, b0 + 6);
      chk("three_done", done_cnt, d0 + 1);
      ready_mode = 1;
      send_char(8'h41); send_char(8'h00); exp_ch = 3'd0;
      // count 0 means 256 samples
      send_char(8'h4E); send_char(8'h00);
      b0 = bytes; d0 = done_cnt;
      send_char(8'h53);
      wait_idle(5000, 1, 0);
      step(); step();
      chk("full_bytes", bytes, b0 + 512);
      chk("full_done", done_cnt, d0 + 1);
      chk("full_sb_empty", sb.size(), 0);
      // abort while converting sample 10
      b0 = bytes; d0 = done_cnt; a0 = ab_cnt;
      vlimit = vcount + 9;
      send_char(8'h53);
      n = 0;
      while (!(adc_req && vcount == vlimit) && n < 2000) begin step(); n++; end
      chk("abort_reach_s10", adc_req && vcount == vlimit, 1);
      send_char(8'h58);
      chk("abort_adc_req", adc_req, 0);
      chk("abort_pulse", aborted, 1);
      chk("abort_busy", busy, 0);
      step(); step();
      chk("abort_bytes", bytes, b0 + 18);
      chk("abort_cnt", ab_cnt, a0 + 1);
      chk("abort_no_done", done_cnt, d0);
      // abort coinciding with adc_valid still sends the sample
      send_char(8'h4E); send_char(8'h03);
      vlimit = vcount;
      b0 = bytes; d0 = done_cnt; a0 = ab_cnt;
      send_char(8'h53);
      step();
      chk("coin_adc_req", adc_req, 1);
      force_fire = 1;
      send_char(8'h58);
      chk("coin_tx_valid", tx_valid, 1);
      chk("coin_not_aborted", aborted, 0);
      wait_idle(100, 0, 1);
      vlimit = 1 << 30;
      step(); step();
      chk("coin_bytes", bytes, b0 + 2);
      chk("coin_abort_cnt", ab_cnt, a0 + 1);
      chk("coin_no_done", done_cnt, d0);
      // reset while the low byte is stalled
      ready_mode = 0;
      send_char(8'h4E); send_char(8'h04);
      send_char(8'h53);
      wait_tx(100);
      ready_mode = 1;
      step();
      ready_mode = 0;
      step();
      chk("lo_stalled", tx_valid, 1);
      rst = 1'b1;
      step();
      chk_zero("midrst");
      rst = 1'b0;
      ready_mode = 1;
      b0 = bytes; d0 = done_cnt;
      send_char(8'h53);
      wait_idle(200, 1, 0);
      step(); step();
      chk("rst_count_bytes", bytes, b0 + 2);
      chk("rst_count_done", done_cnt, d0 + 1);
      // 'X' on the final low-byte transfer yields done
      ready_mode = 0;
      b0 = bytes; d0 = done_cnt; a0 = ab_cnt;
      send_char(8'h53);
      wait_tx(100);
      ready_mode = 1;
      step();
      send_char(8'h58);
      chk("lastx_done", done, 1);
      chk("lastx_aborted", aborted, 0);
      chk("lastx_busy", busy, 0);
      step(); step();
      chk("lastx_bytes", bytes, b0 + 2);
      chk("lastx_done_cnt", done_cnt, d0 + 1);
      chk("lastx_ab_cnt", ab_cnt, a0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/adc_cmd_sequencer.md
# adc_cmd_sequencer

Command-driven controller between the UART receive path, the ADC sampling interface and the UART transmit path. It decodes single-character commands from the receiver's character stream, sets the channel and sample count, and runs ADC conversions. Each 12-bit result is streamed out as two bytes over a valid/ready transmit handshake.

## Interface
- DEFAULT_COUNT, 1: sample count after reset (8-bit; 0 means 256)
- DEFAULT_CH, 0: ADC channel after reset (0..7)

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rx_char  in  8  received character; valid only while rx_valid=1
- rx_valid  in  1  one-cycle strobe per received character
- adc_req  out  1  conversion request, level, held until adc_valid
- adc_ch  out  3  channel for the current request
- adc_valid  in  1  one-cycle strobe, conversion complete
- adc_data  in  12  conversion result, valid with adc_valid
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts; transfer = tx_valid & tx_ready at a rising edge
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse, capture completed normally
- aborted  out  1  one-cycle pulse, capture ended by abort
- cmd_err  out  1  one-cycle pulse, bad command or argument

## Operation
- States: IDLE, ARG_N, ARG_A, CONVERT, SEND_HI, SEND_LO.
- IDLE, with rx_valid:
  - 'N' (0x4E) -> ARG_N
  - 'A' (0x41) -> ARG_A
  - 'S' (0x53) -> CONVERT; remaining = count (0 loads 256)
  - 'X' (0x58) -> ignored, no error
  - any other char -> cmd_err pulse, stay IDLE
- ARG_N: next rx byte -> count (any value; 0 = 256) -> IDLE.
- ARG_A: next byte <= 7 -> channel; byte > 7 -> cmd_err, channel unchanged; either way -> IDLE.
  - Exception: 'X' received in ARG_N or ARG_A cancels without updating -> IDLE, no error.
- CONVERT: adc_req=1, adc_ch=channel. On adc_valid, latch adc_data -> SEND_HI.
- SEND_HI: tx_data = {channel[2:0], 1'b0, sample[11:8]}; on transfer -> SEND_LO.
- SEND_LO: tx_data = sample[7:0]. On transfer, decrement remaining:
  - remaining reaches 0 -> IDLE with done.
  - abort pending -> IDLE with aborted.
  - otherwise -> CONVERT.
- Abort:
  - In CONVERT/SEND_*, rx 'X' sets abort_pending; all other rx chars are dropped silently (no cmd_err).
  - CONVERT with abort_pending and no adc_valid that cycle -> drop adc_req -> IDLE, aborted pulse.
  - A sample already latched is always sent completely (both bytes).
- adc_valid outside CONVERT is ignored.
- tx_valid/tx_data never change or drop while tx_valid=1 and tx_ready=0.

## Timing
- Reset values:
  - all outputs 0; tx_data = 0x00.
  - state IDLE; count = DEFAULT_COUNT, channel = DEFAULT_CH, abort_pending = 0.
- rst mid-capture: same values next cycle; an in-flight conversion result is discarded.
- All outputs are registered.
- 'S' strobe at cycle t -> adc_req=1, busy=1 at t+1.
- adc_valid at u -> adc_req=0, tx_valid=1 (hi byte) at u+1.
- Hi transfer at v -> lo byte presented at v+1.
- Lo transfer at w:
  - more samples: adc_req=1 at w+1.
  - last sample: done=1, busy=0, tx_valid=0 at w+1.
- With tx_ready tied high, each sample costs conversion latency + 3 cycles.
- Abort in CONVERT: 'X' at t with no adc_valid -> adc_req=0, aborted=1 at t+1.
- Simultaneous events:
  - 'X' with adc_valid in CONVERT -> the sample is taken and sent, then aborted.
  - 'X' on the final lo-byte transfer -> done, not aborted.
- remaining is 9 bits so 256 is representable; no wrap.

## Test plan
- Reset, then 'S' with defaults -> one adc_req at t+1; adc_data=0xABC -> bytes 0x0A, 0xBC, then done; busy falls.
- 'A',0x05,'N',0x03,'S'; tx_ready toggles 1/0 -> three samples with adc_ch=5, hi bytes 0xA_ ({101,0,nibble}); tx_data stable while stalled; single done.
- 'A',0x09 -> cmd_err pulse, channel stays 0; 'Q' in IDLE -> cmd_err; 'X' in IDLE -> no pulse.
- 'N',0x00,'S' -> 256 samples (512 bytes) then done; 'X' injected in CONVERT of sample 10 -> adc_req drops next cycle, aborted, 18 bytes total.
- 'X' same cycle as adc_valid -> that sample's two bytes sent, then aborted; rst asserted during SEND_LO -> all outputs 0 next cycle, count = DEFAULT_COUNT.
